tl_injector: RTL and testbench
==============================

TL_INJECTOR -- requirements
Module: tl_injector

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- AXI_D_WIDTH, 24, AXI-stream data width
- D_WIDTH, 32, flit width; D_WIDTH >= AXI_D_WIDTH + TYPE_BITS
- TYPE_BITS, 2, flit type field width
- DEST_BITS, 4, destination field width
- NUM_VC, 12, number of virtual channels; >= 2
- BUF_DEPTH, 12, downstream buffer depth per VC
- CREDIT_BITS, $clog2(BUF_DEPTH+1), derived, not overridable
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, reset: synchronous, active-high
- in_tdata, in, AXI_D_WIDTH, payload beat
- in_tvalid, in, 1, beat valid
- in_tlast, in, 1, last beat of packet
- in_tuser, in, DEST_BITS, destination; sampled on the first beat only
- in_tready, out, 1, beat accepted when in_tvalid && in_tready
- flit_o, out, D_WIDTH, registered flit
- flit_valid_o, out, 1, flit_o valid this cycle
- flit_vc_o, out, $clog2(NUM_VC), VC index of flit_o
- credit_ret_i, in, NUM_VC, one credit returned per set bit per cycle
- vc_credits_o, out, NUM_VC x CREDIT_BITS, current credit counters
- busy_o, out, 1, FSM not in IDLE
- err_o, out, 1, sticky credit-overflow flag

Function
REQ-003 Flit format: type in bits [D_WIDTH-1 -: TYPE_BITS].
- HEAD = 01; BODY = 00; TAIL = 10; 11 reserved, never emitted.
- Head payload = in_tuser in the low DEST_BITS, all other bits zero.
- Body/tail payload = in_tdata zero-extended.
REQ-004 FSM states: IDLE and PAYLOAD.
REQ-005 IDLE: in_tready = 0; if in_tvalid && max credit > 0, the FSM shall:
- lock the selected VC;
- register a HEAD flit on that VC;
- go to PAYLOAD.
REQ-006 VC selection: VC with the largest credit count; ties go to the lowest index; selection uses the registered counters of the current cycle.
REQ-007 PAYLOAD: in_tready = (credits[locked VC] > 0); on handshake register a flit on the locked VC:
- in_tlast = 1: TAIL flit, FSM goes to IDLE;
- in_tlast = 0: BODY flit, FSM stays in PAYLOAD.
REQ-008 A single-beat packet shall produce HEAD followed by TAIL, with no idle cycle between them when credits allow.
REQ-009 Latency: flit_valid_o, flit_o and flit_vc_o assert the cycle after the decision/handshake edge; flit_valid_o is high for exactly one cycle per flit.
REQ-010 Credit counter per VC:
- decrement on each flit issued to that VC, at the same edge the flit is registered;
- increment on credit_ret_i[v];
- both in the same cycle: unchanged.
REQ-011 An increment while a counter equals BUF_DEPTH shall saturate the counter and set err_o; err_o is cleared only by rst.
REQ-012 A decrement at 0 shall be impossible by construction; the bench shall assert this.
REQ-013 The locked VC shall not change before TAIL, even if another VC gains more credits.
REQ-014 in_tvalid dropping mid-packet shall leave the FSM in PAYLOAD with no flit issued.

Reset
REQ-015 On rst:
- FSM = IDLE;
- all credit counters = BUF_DEPTH;
- flit_valid_o, in_tready, busy_o, err_o = 0;
- flit_o and flit_vc_o = 0.
REQ-016 rst mid-packet shall abandon the packet; no TAIL is generated, and the first cycle after reset behaves as IDLE.

Structure
REQ-017 Package tl_pkg shall hold:
- flit-type enum (HEAD/BODY/TAIL);
- FSM state enum;
- TYPE_BITS constant.
REQ-018 Sub-module tl_argmax:
- parametric comparator tree over NUM_VC counters (any NUM_VC, non-power-of-2 included);
- outputs max index and max value, lowest index on ties;
- purely combinational.

Verification
REQ-019 After reset, a 3-beat packet with dest=5 -> flits HEAD(payload 5) on VC0, then BODY, BODY, TAIL on VC0; vc_credits_o[0] = 8.
REQ-020 Credits preloaded so VC3 = 12, VC7 = 12, others lower; send a packet -> flits go on VC3; a credit return to VC7 mid-packet does not move the packet.
REQ-021 Locked VC at 1 credit, 3-beat packet -> HEAD consumes the credit; in_tready stays 0 until credit_ret_i[vc] pulses; one beat accepted per returned credit.
REQ-022 Single-beat packet with in_tdata = 0xABCDEF -> HEAD then TAIL on consecutive cycles; TAIL payload = 0x00ABCDEF with type 10.
REQ-023 Credit return plus flit issue on the same VC in the same cycle -> counter unchanged; a credit return to a VC at 12 -> counter stays 12 and err_o = 1 until rst.
REQ-024 rst asserted during BODY beats -> next cycle FSM is IDLE, all counters = 12, and no TAIL is emitted.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared flit-type and FSM encodings for the tl_injector slice.
// Latency: none (types and constants only).
// Backpressure: n/a.
package tl_pkg;

  localparam int TYPE_BITS = 2;

  // Flit type field values; 2'b11 is reserved and never generated.
  typedef enum logic [TYPE_BITS-1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10
  } flit_type_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } tl_state_e;

endpackage

// File: rtl/tl_argmax.sv
// Argmax over NUM_VC packed counters; lowest index wins ties.
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: cnt_flat (counter v in bits [v*CNT_BITS +: CNT_BITS]) -> max_idx, max_val.
module tl_argmax #(
  parameter int  NUM_VC   = 12,
  parameter int  CNT_BITS = 4,
  localparam int IDX_BITS = $clog2(NUM_VC)
) (
  input  logic [NUM_VC*CNT_BITS-1:0] cnt_flat,
  output logic [IDX_BITS-1:0]        max_idx,
  output logic [CNT_BITS-1:0]        max_val
);

  // Binary tree padded to a power of two: node n has children 2n and 2n+1,
  // leaves sit at LEAVES+k. Padding leaves hold value 0 and sit to the right
  // of every real leaf, so they can never win (right wins only if strictly
  // greater), which also gives the lowest-index tie break.
  localparam int LEAVES = 1 << $clog2(NUM_VC);

  logic [CNT_BITS-1:0] node_val [1:2*LEAVES-1];
  logic [IDX_BITS-1:0] node_idx [1:2*LEAVES-1];

  always_comb begin
    for (int n = 1; n < 2*LEAVES; n++) begin
      node_val[n] = '0;
      node_idx[n] = '0;
    end
    for (int k = 0; k < NUM_VC; k++) begin
      node_val[LEAVES+k] = cnt_flat[k*CNT_BITS +: CNT_BITS];
      node_idx[LEAVES+k] = IDX_BITS'(k);
    end
    for (int n = LEAVES-1; n >= 1; n--) begin
      if (node_val[2*n+1] > node_val[2*n]) begin
        node_val[n] = node_val[2*n+1];
        node_idx[n] = node_idx[2*n+1];
      end else begin
        node_val[n] = node_val[2*n];
        node_idx[n] = node_idx[2*n];
      end
    end
  end

  assign max_idx = node_idx[1];
  assign max_val = node_val[1];

endmodule

// File: rtl/tl_injector.sv
// AXI-stream to flit injector: one HEAD per packet, then BODY/TAIL per beat,
// on the VC with most credits, locked until TAIL.
// Latency: flit registered one cycle after the decision/handshake edge.
// Backpressure: in_tready low in IDLE and whenever the locked VC has no credit.
// Ports: in_t* AXI-stream slave; flit_o/flit_valid_o/flit_vc_o flit out;
//        credit_ret_i per-VC credit return; vc_credits_o counters; busy_o, err_o.
module tl_injector
  import tl_pkg::*;
#(
  parameter int  AXI_D_WIDTH = 24,
  parameter int  D_WIDTH     = 32,
  parameter int  TYPE_BITS   = 2,
  parameter int  DEST_BITS   = 4,
  parameter int  NUM_VC      = 12,
  parameter int  BUF_DEPTH   = 12,
  localparam int CREDIT_BITS = $clog2(BUF_DEPTH+1),
  localparam int VC_BITS     = $clog2(NUM_VC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI_D_WIDTH-1:0]        in_tdata,
  input  logic                          in_tvalid,
  input  logic                          in_tlast,
  input  logic [DEST_BITS-1:0]          in_tuser,
  output logic                          in_tready,
  output logic [D_WIDTH-1:0]            flit_o,
  output logic                          flit_valid_o,
  output logic [VC_BITS-1:0]            flit_vc_o,
  input  logic [NUM_VC-1:0]             credit_ret_i,
  output logic [NUM_VC*CREDIT_BITS-1:0] vc_credits_o,
  output logic                          busy_o,
  output logic                          err_o
);

  tl_state_e                state_q, state_d;
  logic [VC_BITS-1:0]       lock_vc_q;
  logic [CREDIT_BITS-1:0]   cred_q [NUM_VC];

  logic [VC_BITS-1:0]       max_idx;
  logic [CREDIT_BITS-1:0]   max_val;
  logic                     lock_has_cred;
  logic                     head_go;
  logic                     beat_go;
  logic                     issue;
  logic [VC_BITS-1:0]       issue_vc;
  logic [D_WIDTH-1:0]       flit_d;
  logic [NUM_VC-1:0]        cred_dec;
  logic [NUM_VC-1:0]        cred_ovf;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_cred_out
    assign vc_credits_o[v*CREDIT_BITS +: CREDIT_BITS] = cred_q[v];
  end

  tl_argmax #(
    .NUM_VC   (NUM_VC),
    .CNT_BITS (CREDIT_BITS)
  ) u_argmax (
    .cnt_flat (vc_credits_o),
    .max_idx  (max_idx),
    .max_val  (max_val)
  );

  assign lock_has_cred = (cred_q[lock_vc_q] != '0);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (head_go)             state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (beat_go && in_tlast) state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. The first data beat is never consumed in IDLE; the HEAD
  // is built from in_tuser while that beat waits for PAYLOAD.
  always_comb begin
    in_tready = 1'b0;
    busy_o    = 1'b0;
    head_go   = 1'b0;
    beat_go   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        head_go = in_tvalid && (max_val != '0);
      end
      ST_PAYLOAD: begin
        busy_o    = 1'b1;
        in_tready = lock_has_cred && !rst;
        beat_go   = in_tvalid && lock_has_cred;
      end
      default: ;
    endcase
  end

  // Both issue paths require a non-zero counter on the target VC, so a
  // counter can never be decremented below zero.
  assign issue    = head_go || beat_go;
  assign issue_vc = head_go ? max_idx : lock_vc_q;

  always_comb begin
    flit_d = '0;
    if (head_go) begin
      flit_d[D_WIDTH-1 -: TYPE_BITS] = TYPE_BITS'(FLIT_HEAD);
      flit_d[DEST_BITS-1:0]          = in_tuser;
    end else begin
      flit_d[D_WIDTH-1 -: TYPE_BITS] = TYPE_BITS'(in_tlast ? FLIT_TAIL : FLIT_BODY);
      flit_d[AXI_D_WIDTH-1:0]        = in_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_valid_o <= 1'b0;
      flit_o       <= '0;
      flit_vc_o    <= '0;
      lock_vc_q    <= '0;
    end else begin
      flit_valid_o <= issue;
      if (issue) begin
        flit_o    <= flit_d;
        flit_vc_o <= issue_vc;
      end
      if (head_go) lock_vc_q <= max_idx;
    end
  end

  // Return and issue on the same VC in one cycle cancel out. A lone return
  // to a full counter is an upstream accounting bug: hold and flag it.
  always_comb begin
    cred_dec = '0;
    cred_ovf = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      cred_dec[v] = issue && (issue_vc == VC_BITS'(v));
      cred_ovf[v] = credit_ret_i[v] && !cred_dec[v] &&
                    (cred_q[v] == CREDIT_BITS'(BUF_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= CREDIT_BITS'(BUF_DEPTH);
      err_o <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (credit_ret_i[v] && !cred_dec[v] && !cred_ovf[v])
          cred_q[v] <= cred_q[v] + 1'b1;
        else if (cred_dec[v] && !credit_ret_i[v])
          cred_q[v] <= cred_q[v] - 1'b1;
      end
      err_o <= err_o | (|cred_ovf);
    end
  end

endmodule

// File: tb/tb_tl_injector.sv
// Self-checking bench for tl_injector: directed scenarios plus random packets
// checked each cycle against a packet-level behavioural model.
module tb_tl_injector;
  import tl_pkg::*;

  localparam int NV    = 12;
  localparam int DEPTH = 12;
  localparam int CB    = 4;
  localparam int VB    = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [23:0]    in_tdata;
  logic           in_tvalid;
  logic           in_tlast;
  logic [3:0]     in_tuser;
  logic           in_tready;
  logic [31:0]    flit_o;
  logic           flit_valid_o;
  logic [VB-1:0]  flit_vc_o;
  logic [NV-1:0]  credit_ret_i;
  logic [NV*CB-1:0] vc_credits_o;
  logic           busy_o;
  logic           err_o;

  tl_injector #(
    .AXI_D_WIDTH (24),
    .D_WIDTH     (32),
    .TYPE_BITS   (2),
    .DEST_BITS   (4),
    .NUM_VC      (NV),
    .BUF_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_tdata     (in_tdata),
    .in_tvalid    (in_tvalid),
    .in_tlast     (in_tlast),
    .in_tuser     (in_tuser),
    .in_tready    (in_tready),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .flit_vc_o    (flit_vc_o),
    .credit_ret_i (credit_ret_i),
    .vc_credits_o (vc_credits_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: credits per VC, whether a packet is open and on which VC.
  int          m_cred [NV];
  bit          m_inpkt;
  int          m_vc;
  bit          m_err;
  bit          m_acc;
  bit          m_vld;
  bit          m_dat;
  logic [31:0] m_flit;
  int          m_fvc;
  int          cyc = 0;
  int          stall_cnt = 0;

  logic [31:0] obs_flit [$];
  int          obs_vc   [$];
  int          obs_cyc  [$];

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_cred[v] = DEPTH;
    m_inpkt = 0;
    m_vc    = 0;
    m_err   = 0;
    m_flit  = '0;
    m_fvc   = 0;
  endtask

  function automatic logic [NV-1:0] rand_ret(input int pct);
    logic [NV-1:0] r = '0;
    for (int v = 0; v < NV; v++)
      if (m_cred[v] < DEPTH && int'($urandom_range(99)) < pct) r[v] = 1'b1;
    return r;
  endfunction

  // One clock: predict the edge from the current inputs, then compare.
  task automatic step();
    bit          rdy;
    bit          issue;
    int          ivc;
    int          best;
    int          bi;
    logic [31:0] f;
    logic [NV*CB-1:0] pk;
    bit          bound_ok;
    #1;
    rdy = !rst && m_inpkt && (m_cred[m_vc] > 0);
    chk("in_tready", in_tready, rdy);
    if (m_inpkt && !in_tready) stall_cnt++;
    m_acc = 0;
    issue = 0;
    ivc   = 0;
    f     = '0;
    m_dat = 0;
    if (rst) begin
      model_reset();
      m_vld = 0;
      m_dat = 1;
    end else begin
      best = 0;
      bi   = 0;
      for (int v = 0; v < NV; v++)
        if (m_cred[v] > best) begin best = m_cred[v]; bi = v; end
      if (!m_inpkt) begin
        if (in_tvalid && best > 0) begin
          issue   = 1;
          ivc     = bi;
          f       = (32'(FLIT_HEAD) << 30) | 32'(in_tuser);
          m_inpkt = 1;
          m_vc    = bi;
        end
      end else if (in_tvalid && rdy) begin
        issue = 1;
        ivc   = m_vc;
        m_acc = 1;
        f     = (32'(in_tlast ? FLIT_TAIL : FLIT_BODY) << 30) | 32'(in_tdata);
        if (in_tlast) m_inpkt = 0;
      end
      for (int v = 0; v < NV; v++) begin
        if (credit_ret_i[v] && !(issue && ivc == v)) begin
          if (m_cred[v] == DEPTH) m_err = 1;
          else m_cred[v] = m_cred[v] + 1;
        end else if (issue && ivc == v && !credit_ret_i[v]) begin
          m_cred[v] = m_cred[v] - 1;
        end
      end
      m_vld = issue;
      if (issue) begin
        m_flit = f;
        m_fvc  = ivc;
        m_dat  = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("flit_valid", flit_valid_o, m_vld);
    if (m_dat) begin
      chk("flit_data", flit_o, m_flit);
      chk("flit_vc", flit_vc_o, m_fvc);
    end
    pk = '0;
    bound_ok = 1;
    for (int v = 0; v < NV; v++) begin
      pk[v*CB +: CB] = CB'(m_cred[v]);
      if (vc_credits_o[v*CB +: CB] > DEPTH) bound_ok = 0;
    end
    chk("credits", vc_credits_o, pk);
    chk("no_underflow", bound_ok, 1);
    chk("err", err_o, m_err);
    chk("busy", busy_o, m_inpkt);
    if (flit_valid_o) begin
      obs_flit.push_back(flit_o);
      obs_vc.push_back(int'(flit_vc_o));
      obs_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n, input int pct);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    for (int i = 0; i < n; i++) begin
      credit_ret_i = rand_ret(pct);
      step();
    end
    credit_ret_i = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    credit_ret_i = '0;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  // Drives one packet; the bench model says when each beat was accepted.
  task automatic send_pkt(input logic [3:0] dest, input int nbeats, input logic [23:0] d0,
                          input int drop_pct, input int ret_pct, input bit pulse_lock,
                          input int force_vc, input int force_at, input int rst_at);
    int          b = 0;
    int          budget = 0;
    bit          forced = 0;
    bit          aborted = 0;
    logic [23:0] d = d0;
    while (b < nbeats && budget < 2000 && !aborted) begin
      in_tvalid    = (int'($urandom_range(99)) >= drop_pct);
      in_tdata     = d;
      in_tlast     = (b == nbeats - 1);
      in_tuser     = m_inpkt ? 4'($urandom) : dest;
      credit_ret_i = rand_ret(ret_pct);
      if (pulse_lock && m_inpkt && (budget % 4 == 3)) credit_ret_i[m_vc] = 1'b1;
      if (!forced && force_vc >= 0 && b == force_at) begin
        credit_ret_i[force_vc] = 1'b1;
        forced = 1;
      end
      if (rst_at >= 0 && b == rst_at && m_inpkt) begin
        rst = 1'b1;
        aborted = 1;
      end
      step();
      rst = 1'b0;
      if (m_acc) begin
        b++;
        d = 24'($urandom);
      end
      budget++;
    end
    in_tvalid    = 1'b0;
    in_tlast     = 1'b0;
    credit_ret_i = '0;
    if (!aborted) chk("pkt_beats", b, nbeats);
  endtask

  initial begin
    int s;
    int n;
    int ntail;
    bit all_ok;

    rst = 1'b1;
    in_tdata = '0;
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    in_tuser = '0;
    credit_ret_i = '0;
    model_reset();
    m_vld = 0;

    // Reset state.
    do_reset(2);
    chk("rst_vc0", vc_credits_o[3:0], 12);
    chk("rst_busy", busy_o, 0);

    // 3-beat packet, dest 5, fresh after reset.
    s = obs_flit.size();
    send_pkt(4'd5, 3, 24'h123456, 0, 0, 0, -1, -1, -1);
    idle(1, 0);
    n = obs_flit.size() - s;
    chk("pkt3_nflits", n, 4);
    if (n >= 4) begin
      chk("pkt3_head", obs_flit[s], 32'h4000_0005);
      chk("pkt3_tail_type", obs_flit[s+3][31:30], 2);
      chk("pkt3_vc", obs_vc[s] + obs_vc[s+1] + obs_vc[s+2] + obs_vc[s+3], 0);
    end
    chk("pkt3_vc0_credits", vc_credits_o[3:0], 8);

    // Single-beat packet: HEAD and TAIL back to back.
    s = obs_flit.size();
    send_pkt(4'hA, 1, 24'hABCDEF, 0, 0, 0, -1, -1, -1);
    idle(1, 0);
    n = obs_flit.size() - s;
    chk("single_nflits", n, 2);
    if (n >= 2) begin
      chk("single_head_type", obs_flit[s][31:30], 1);
      chk("single_tail", obs_flit[s+1], 32'h80AB_CDEF);
      chk("single_gap", obs_cyc[s+1] - obs_cyc[s], 1);
    end

    // Tie at the top between VC3 and VC7; packet must stay on VC3.
    do_reset(1);
    for (int i = 0; i < NV; i++) send_pkt(4'($urandom), 1, 24'($urandom), 0, 0, 0, -1, -1, -1);
    credit_ret_i = 12'h088;
    step();
    step();
    credit_ret_i = '0;
    chk("tie_vc3", vc_credits_o[3*CB +: CB], 12);
    chk("tie_vc7", vc_credits_o[7*CB +: CB], 12);
    s = obs_flit.size();
    send_pkt(4'd9, 4, 24'($urandom), 0, 0, 0, 7, 1, -1);
    idle(1, 0);
    n = obs_flit.size() - s;
    chk("tie_nflits", n, 5);
    all_ok = 1;
    for (int i = s; i < obs_flit.size(); i++) if (obs_vc[i] != 3) all_ok = 0;
    chk("tie_locked_vc3", all_ok, 1);

    // Same-cycle return and issue on VC0, then overflow on VC1.
    do_reset(1);
    send_pkt(4'd2, 1, 24'($urandom), 0, 0, 0, 0, 0, -1);
    chk("cancel_vc0", vc_credits_o[3:0], 11);
    chk("cancel_no_err", err_o, 0);
    credit_ret_i = 12'h002;
    step();
    credit_ret_i = '0;
    chk("ovf_vc1_sat", vc_credits_o[CB +: CB], 12);
    chk("ovf_err", err_o, 1);
    idle(3, 0);
    chk("ovf_err_sticky", err_o, 1);
    do_reset(1);
    chk("ovf_err_cleared", err_o, 0);

    // Drain every VC to 1 credit, then a 3-beat packet paced by returns.
    for (int i = 0; i < NV; i++) send_pkt(4'($urandom), 10, 24'($urandom), 0, 0, 0, -1, -1, -1);
    chk("drain_all_one", vc_credits_o, 48'h1111_1111_1111);
    stall_cnt = 0;
    s = obs_flit.size();
    send_pkt(4'd3, 3, 24'($urandom), 0, 0, 1, -1, -1, -1);
    chk("paced_stalled", stall_cnt > 0, 1);
    chk("paced_nflits", obs_flit.size() - s, 4);

    // Reset in the middle of BODY beats.
    do_reset(1);
    s = obs_flit.size();
    send_pkt(4'd6, 6, 24'($urandom), 0, 0, 0, -1, -1, 2);
    chk("abort_busy", busy_o, 0);
    chk("abort_credits", vc_credits_o, 48'hCCCC_CCCC_CCCC);
    idle(2, 0);
    ntail = 0;
    for (int i = s; i < obs_flit.size(); i++) if (obs_flit[i][31:30] == 2'b10) ntail++;
    chk("abort_no_tail", ntail, 0);
    send_pkt(4'd1, 2, 24'($urandom), 0, 0, 0, -1, -1, -1);

    // Random traffic with dropped valids and random credit returns.
    do_reset(1);
    for (int i = 0; i < 40; i++) begin
      send_pkt(4'($urandom), int'($urandom_range(1, 6)), 24'($urandom), 20, 15, 0, -1, -1, -1);
      idle(int'($urandom_range(0, 2)), 15);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
